acumulador_bcd: RTL and testbench

ACUMULADOR_BCD -- requirements
Module: acumulador_bcd

---
 rtl/acumulador_bcd_if.sv | 23 ++
 rtl/acumulador_bcd.sv | 95 +++++++++
 tb/tb_acumulador_bcd.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_bcd_if.sv
// acumulador_bcd_if: operand/control and BCD result bundle for acumulador_bcd
// master: drives a, start, clr (and sub when ACUMULADOR_BCD_SUB_EN is defined)
// slave:  drives dez, uni, ocupado, pronto, ovf
interface acumulador_bcd_if;
  logic [3:0] a;
  logic start;
  logic clr;
`ifdef ACUMULADOR_BCD_SUB_EN
  logic sub;
`endif
  logic [3:0] dez;
  logic [3:0] uni;
  logic ocupado;
  logic pronto;
  logic ovf;
`ifdef ACUMULADOR_BCD_SUB_EN
  modport master(output a, start, clr, sub, input dez, uni, ocupado, pronto, ovf);
  modport slave(input a, start, clr, sub, output dez, uni, ocupado, pronto, ovf);
`else
  modport master(output a, start, clr, input dez, uni, ocupado, pronto, ovf);
  modport slave(input a, start, clr, output dez, uni, ocupado, pronto, ovf);
`endif
endinterface

// File: rtl/acumulador_bcd.sv
// acumulador_bcd: mod-100 accumulator with shift-and-add-3 conversion to two BCD digits
// clk, rst (sync, active-high); bus: a/start/clr in, dez/uni/ocupado/pronto/ovf out
// ACUMULADOR_BCD_SUB_EN adds bus.sub: subtract a instead of adding, borrowing wraps +100
module acumulador_bcd (
  input logic clk,
  input logic rst,
  acumulador_bcd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SOMA, CONV, FIM} state_t;
  state_t st;
  logic [6:0] acc;
  logic [6:0] op;
  logic sub_q;
  logic [14:0] sr;
  logic [14:0] adj;
  logic [2:0] cnt;
  logic [7:0] s;
  logic [6:0] nxt;
  logic wrap;
  logic [3:0] dez_q;
  logic [3:0] uni_q;
  logic ocupado_q;
  logic pronto_q;
  logic ovf_q;
  always_comb begin
    s = {1'b0, acc} + {1'b0, op};
    wrap = s > 8'd99;
    nxt = wrap ? 7'(s - 8'd100) : s[6:0];
    if (sub_q) begin
      wrap = acc < op;
      nxt = wrap ? acc + 7'd100 - op : acc - op;
    end
    adj = {sr[14:11] > 4'd4 ? sr[14:11] + 4'd3 : sr[14:11],
           sr[10:7] > 4'd4 ? sr[10:7] + 4'd3 : sr[10:7], sr[6:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      acc <= '0;
      op <= '0;
      sub_q <= 1'b0;
      sr <= '0;
      cnt <= '0;
      dez_q <= '0;
      uni_q <= '0;
      ocupado_q <= 1'b0;
      pronto_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (st)
        IDLE:
          if (bus.clr) begin
            acc <= '0;
            dez_q <= '0;
            uni_q <= '0;
            ovf_q <= 1'b0;
          end else if (bus.start) begin
            op <= {3'b0, bus.a};
`ifdef ACUMULADOR_BCD_SUB_EN
            sub_q <= bus.sub;
`else
            sub_q <= 1'b0;
`endif
            ocupado_q <= 1'b1;
            st <= SOMA;
          end
        SOMA: begin
          acc <= nxt;
          ovf_q <= ovf_q | wrap;
          sr <= {8'd0, nxt};
          cnt <= '0;
          st <= CONV;
        end
        CONV: begin
          sr <= {adj[13:0], 1'b0};
          cnt <= cnt + 3'd1;
          st <= cnt == 3'd6 ? FIM : CONV;
        end
        default: begin
          dez_q <= sr[14:11];
          uni_q <= sr[10:7];
          pronto_q <= 1'b1;
          ocupado_q <= 1'b0;
          st <= IDLE;
        end
      endcase
    end
  end
  assign bus.dez = dez_q;
  assign bus.uni = uni_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto = pronto_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_acumulador_bcd.sv
// tb_acumulador_bcd: randomized self-checking bench for acumulador_bcd against a decimal model
module tb_acumulador_bcd;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  acumulador_bcd_if bus();
  acumulador_bcd dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int macc = 0;
  bit movf = 1'b0;

  function automatic logic [8:0] model_word();
    return {movf, 4'(macc / 10), 4'(macc % 10)};
  endfunction

  function automatic void model_step(input int av, input bit sb);
    if (sb) begin
      macc -= av;
      if (macc < 0) begin macc += 100; movf = 1'b1; end
    end else begin
      macc += av;
      if (macc >= 100) begin macc -= 100; movf = 1'b1; end
    end
  endfunction

  task automatic do_op(input logic [3:0] av, input bit sb, input int clr_at,
                       output int lat, output int busy, output bit held);
    logic [3:0] d0;
    logic [3:0] u0;
    d0 = bus.dez;
    u0 = bus.uni;
    bus.a = av;
`ifdef ACUMULADOR_BCD_SUB_EN
    bus.sub = sb;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy = 0;
    held = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (bus.ocupado) busy++;
      if (bus.pronto) begin lat = k; bus.clr = 1'b0; break; end
      if (bus.dez !== d0 || bus.uni !== u0) held = 1'b0;
      bus.clr = (k == clr_at);
      @(negedge clk);
    end
    model_step(int'(av), sb);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.a = 4'd9;
    bus.start = 1'b1;
    bus.clr = 1'b0;
`ifdef ACUMULADOR_BCD_SUB_EN
    bus.sub = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.ocupado, bus.pronto, bus.ovf, bus.dez, bus.uni} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", {bus.ocupado, bus.pronto, bus.ovf, bus.dez, bus.uni});
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ocupado !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_ocupado got=%b exp=0", bus.ocupado);
    end
    macc = 0;
    movf = 1'b0;
  endtask

  task automatic test_basic;
    int seq[10] = '{7, 9, 15, 15, 15, 15, 15, 4, 8, 1};
    logic [8:0] exp_w[10] = '{9'h007, 9'h016, 9'h031, 9'h046, 9'h061, 9'h076, 9'h091, 9'h095, 9'h103, 9'h104};
    int lat, busy;
    bit held;
    for (int i = 0; i < 10; i++) begin
      do_op(4'(seq[i]), 1'b0, 0, lat, busy, held);
      total++;
      if (lat !== 10) begin bad++; $display("FAIL basic_latency op=%0d got=%0d exp=10", i, lat); end
      total++;
      if ({bus.ovf, bus.dez, bus.uni} !== exp_w[i]) begin
        bad++;
        $display("FAIL basic_result op=%0d got=%h exp=%h", i, {bus.ovf, bus.dez, bus.uni}, exp_w[i]);
      end
      if (i == 0) begin
        total++;
        if (busy !== 9) begin bad++; $display("FAIL basic_ocupado_cycles got=%0d exp=9", busy); end
        total++;
        if (!held) begin bad++; $display("FAIL basic_digits_held got=changed exp=held"); end
        @(negedge clk);
        total++;
        if (bus.pronto !== 1'b0) begin bad++; $display("FAIL basic_pronto_width got=%b exp=0", bus.pronto); end
      end
    end
  endtask

  task automatic test_clr;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    total++;
    if ({bus.pronto, bus.ocupado, bus.ovf, bus.dez, bus.uni} !== 11'd0) begin
      bad++;
      $display("FAIL clr_outputs got=%h exp=000", {bus.pronto, bus.ocupado, bus.ovf, bus.dez, bus.uni});
    end
    macc = 0;
    movf = 1'b0;
  endtask

  task automatic test_back_to_back;
    int npr = 0;
    bus.a = 4'd2;
    bus.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.pronto) begin
        npr++;
        total++;
        if (!((k == 10 && {bus.dez, bus.uni} === 8'h02) || (k == 20 && {bus.dez, bus.uni} === 8'h04))) begin
          bad++;
          $display("FAIL b2b_pulse got=cycle %0d digits %h exp=cycle 10 02 / cycle 20 04", k, {bus.dez, bus.uni});
        end
      end
      if (k == 20) bus.start = 1'b0;
    end
    total++;
    if (npr !== 2) begin bad++; $display("FAIL b2b_pulse_count got=%0d exp=2", npr); end
    model_step(2, 1'b0);
    model_step(2, 1'b0);
  endtask

  task automatic test_clr_start;
    int lat, busy, npr;
    bit held;
    test_clr();
    do_op(4'd15, 1'b0, 0, lat, busy, held);
    do_op(4'd15, 1'b0, 0, lat, busy, held);
    do_op(4'd12, 1'b0, 0, lat, busy, held);
    total++;
    if ({bus.dez, bus.uni} !== 8'h42) begin bad++; $display("FAIL clrstart_setup got=%h exp=42", {bus.dez, bus.uni}); end
    bus.a = 4'd3;
    bus.start = 1'b1;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr = 1'b0;
    total++;
    if ({bus.ocupado, bus.ovf, bus.dez, bus.uni} !== 10'd0) begin
      bad++;
      $display("FAIL clrstart_result got=%h exp=000", {bus.ocupado, bus.ovf, bus.dez, bus.uni});
    end
    npr = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.pronto || bus.ocupado) npr++;
      @(negedge clk);
    end
    total++;
    if (npr !== 0) begin bad++; $display("FAIL clrstart_no_op got=%0d active cycles exp=0", npr); end
    macc = 0;
    movf = 1'b0;
  endtask

  task automatic test_clr_ignored;
    int lat, busy;
    bit held;
    do_op(4'd6, 1'b0, 5, lat, busy, held);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL clrign_latency got=%0d exp=10", lat); end
    total++;
    if ({bus.ovf, bus.dez, bus.uni} !== 9'h006) begin
      bad++;
      $display("FAIL clrign_result got=%h exp=006", {bus.ovf, bus.dez, bus.uni});
    end
  endtask

  task automatic test_rst_abort;
    int npr = 0;
    int lat, busy;
    bit held;
    bus.a = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (bus.pronto) npr++;
      if (k == 6) begin
        total++;
        if ({bus.ocupado, bus.pronto, bus.ovf, bus.dez, bus.uni} !== 11'd0) begin
          bad++;
          $display("FAIL rst_abort_outputs got=%h exp=000", {bus.ocupado, bus.pronto, bus.ovf, bus.dez, bus.uni});
        end
      end
      rst = (k == 5);
      @(negedge clk);
    end
    total++;
    if (npr !== 0) begin bad++; $display("FAIL rst_abort_pronto got=%0d exp=0", npr); end
    macc = 0;
    movf = 1'b0;
    do_op(4'd5, 1'b0, 0, lat, busy, held);
    total++;
    if ({bus.ovf, bus.dez, bus.uni} !== 9'h005) begin
      bad++;
      $display("FAIL rst_abort_after got=%h exp=005", {bus.ovf, bus.dez, bus.uni});
    end
  endtask

  task automatic test_random;
    int lat, busy;
    bit held, sb;
    logic [3:0] av;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        test_clr();
      end else begin
        av = 4'($urandom_range(0, 15));
`ifdef ACUMULADOR_BCD_SUB_EN
        sb = 1'($urandom_range(0, 1));
`else
        sb = 1'b0;
`endif
        do_op(av, sb, 0, lat, busy, held);
        total++;
        if (lat !== 10 || {bus.ovf, bus.dez, bus.uni} !== model_word()) begin
          bad++;
          $display("FAIL random_op i=%0d a=%0d sub=%0d got=lat %0d %h exp=lat 10 %h",
                   i, av, sb, lat, {bus.ovf, bus.dez, bus.uni}, model_word());
        end
      end
    end
  endtask

`ifdef ACUMULADOR_BCD_SUB_EN
  task automatic test_sub;
    int lat, busy;
    bit held;
    test_clr();
    do_op(4'd3, 1'b0, 0, lat, busy, held);
    do_op(4'd5, 1'b1, 0, lat, busy, held);
    total++;
    if ({bus.ovf, bus.dez, bus.uni} !== 9'h198) begin
      bad++;
      $display("FAIL sub_borrow got=%h exp=198", {bus.ovf, bus.dez, bus.uni});
    end
    do_op(4'd15, 1'b1, 0, lat, busy, held);
    total++;
    if ({bus.ovf, bus.dez, bus.uni} !== 9'h183) begin
      bad++;
      $display("FAIL sub_plain got=%h exp=183", {bus.ovf, bus.dez, bus.uni});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clr();
    test_back_to_back();
    test_clr_start();
    test_clr_ignored();
    test_rst_abort();
`ifdef ACUMULADOR_BCD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
